// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: MSB-first serial pattern source for sequence detectors; also
// counts adjacent equal-bit pairs in each frame as the expected detector hit count.
`default_nettype none

module seq_pattern_tx #(
  parameter int N  = 16,
  parameter int CW = 5
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          Start,
  input  logic [N-1:0]  Data,
  input  logic [CW-1:0] Len,
  output logic          w,
  output logic          Valid,
  output logic          Busy,
  output logic          Done,
  output logic [CW-1:0] PairCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] N_CW = CW'(N);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] SAT  = '1;

  state_t        state, state_nxt;
  logic [N-1:0]  shreg, shreg_nxt;
  logic [CW-1:0] bit_cnt, bit_cnt_nxt;
  logic [CW-1:0] pair_nxt;
  logic [CW-1:0] len_eff;
  logic          prev_bit, prev_bit_nxt;
  logic          have_prev, have_prev_nxt;
  logic          w_nxt, valid_nxt, busy_nxt, done_nxt;

  assign len_eff = (Len > N_CW) ? N_CW : Len;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      prev_bit  <= 1'b0;
      have_prev <= 1'b0;
      w         <= 1'b0;
      Valid     <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      PairCount <= '0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      bit_cnt   <= bit_cnt_nxt;
      prev_bit  <= prev_bit_nxt;
      have_prev <= have_prev_nxt;
      w         <= w_nxt;
      Valid     <= valid_nxt;
      Busy      <= busy_nxt;
      Done      <= done_nxt;
      PairCount <= pair_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    shreg_nxt     = shreg;
    bit_cnt_nxt   = bit_cnt;
    prev_bit_nxt  = prev_bit;
    have_prev_nxt = have_prev;
    pair_nxt      = PairCount;
    w_nxt         = 1'b0;
    valid_nxt     = 1'b0;
    busy_nxt      = 1'b0;
    done_nxt      = 1'b0;

    case (state)
      IDLE: begin
        if (Start) begin
          pair_nxt      = '0;
          prev_bit_nxt  = 1'b0;
          have_prev_nxt = 1'b0;
          if (len_eff != '0) begin
            shreg_nxt   = Data;
            bit_cnt_nxt = len_eff;
            state_nxt   = SEND;
          end else begin
            state_nxt   = DONE;
          end
        end
      end

      SEND: begin
        w_nxt     = shreg[N-1];
        valid_nxt = 1'b1;
        busy_nxt  = 1'b1;
        // The first bit has no predecessor inside the frame, so it never scores.
        if (have_prev && (shreg[N-1] == prev_bit) && (PairCount != SAT))
          pair_nxt = PairCount + ONE;
        prev_bit_nxt  = shreg[N-1];
        have_prev_nxt = 1'b1;
        shreg_nxt     = {shreg[N-2:0], 1'b0};
        bit_cnt_nxt   = bit_cnt - ONE;
        if (bit_cnt == ONE)
          state_nxt = DONE;
      end

      DONE: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b1;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
// Directed testbench for seq_pattern_tx: hand-computed frames, clamping,
// start-hold behaviour, async reset mid-frame and a randomised frame sweep.
`default_nettype none

module tb_seq_pattern_tx;

  logic        Clock;
  logic        Resetn;
  logic        Start;
  logic [15:0] Data;
  logic [4:0]  Len;
  logic        w;
  logic        Valid;
  logic        Busy;
  logic        Done;
  logic [4:0]  PairCount;

  int tests = 0;
  int fails = 0;

  seq_pattern_tx #(.N(16), .CW(5)) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .Start     (Start),
    .Data      (Data),
    .Len       (Len),
    .w         (w),
    .Valid     (Valid),
    .Busy      (Busy),
    .Done      (Done),
    .PairCount (PairCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic void model(input logic [15:0] d, input logic [4:0] l,
                                output logic [15:0] bits, output int n, output int pc);
    n    = (l > 5'd16) ? 16 : int'(l);
    bits = '0;
    pc   = 0;
    for (int i = 0; i < n; i++) begin
      bits = {bits[14:0], d[15-i]};
      if (i > 0 && d[15-i] == d[16-i]) pc++;
    end
  endfunction

  task automatic send_frame(input string tag, input logic [15:0] d, input logic [4:0] l,
                            input logic [15:0] exp_bits, input int exp_len, input int exp_pc);
    logic [15:0] got;
    int          nvalid;
    int          done_cyc;
    bit          order_ok;
    got = '0; nvalid = 0; done_cyc = -1; order_ok = 1'b1;
    Start = 1'b1; Data = d; Len = l;
    tick();
    Start = 1'b0; Data = 16'($urandom); Len = 5'($urandom);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      tick();
      if (Valid) begin
        got = {got[14:0], w};
        nvalid++;
        if (nvalid != cyc) order_ok = 1'b0;
      end
      if (Done) begin
        done_cyc = cyc;
        break;
      end
    end
    check({tag, ".done_cyc"}, 32'(done_cyc), 32'(exp_len + 1));
    check({tag, ".nvalid"},   32'(nvalid),   32'(exp_len));
    check({tag, ".bits"},     32'(got),      32'(exp_bits));
    check({tag, ".order"},    32'(order_ok), 32'd1);
    check({tag, ".busy_done"}, 32'(Busy),    32'd1);
    check({tag, ".pairs"},    32'(PairCount), 32'(exp_pc));
    tick();
    check({tag, ".idle_after"}, 32'({Done, Busy, Valid, w}), 32'd0);
    check({tag, ".pairs_hold"}, 32'(PairCount), 32'(exp_pc));
  endtask

  initial begin
    logic [15:0] mbits;
    int          mlen;
    int          mpc;
    logic [15:0] got;
    int          nvalid;
    bit          seen;
    logic [15:0] rd;
    logic [4:0]  rl;

    Resetn = 1'b0; Start = 1'b0; Data = '0; Len = '0;
    #1;
    check("reset_outputs", 32'({w, Valid, Busy, Done}), 32'd0);
    check("reset_pairs",   32'(PairCount), 32'd0);
    tick(); tick();
    Resetn = 1'b1;
    tick();
    check("idle_no_start", 32'({w, Valid, Busy, Done}), 32'd0);

    send_frame("f0f0",   16'hF0F0, 5'd16, 16'hF0F0, 16, 12);
    send_frame("aaaa",   16'hAAAA, 5'd16, 16'hAAAA, 16, 0);
    send_frame("ffff",   16'hFFFF, 5'd16, 16'hFFFF, 16, 15);
    send_frame("c000_4", 16'hC000, 5'd4,  16'h000C, 4,  2);
    send_frame("len0",   16'hFFFF, 5'd0,  16'h0000, 0,  0);
    send_frame("len31",  16'h1234, 5'd31, 16'h1234, 16, 7);

    // Start held high across a frame while Data changes mid-frame.
    got = '0; nvalid = 0;
    Start = 1'b1; Data = 16'hA000; Len = 5'd4;
    tick();
    for (int cyc = 1; cyc <= 6; cyc++) begin
      tick();
      if (cyc == 2) Data = 16'hFFFF;
      if (Valid) begin
        got = {got[14:0], w};
        nvalid++;
      end
      if (cyc == 5) check("hold.done_at5", 32'(Done), 32'd1);
    end
    check("hold.bits",      32'(got),    32'h000A);
    check("hold.nvalid",    32'(nvalid), 32'd4);
    check("hold.gap",       32'({Valid, Busy}), 32'd0);
    tick();
    check("hold.next_bit0", 32'({Valid, w}), 32'b11);
    Start = 1'b0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick();
      if (Done) begin
        seen = 1'b1;
        break;
      end
    end
    check("hold.next_done",  32'(seen), 32'd1);
    check("hold.next_pairs", 32'(PairCount), 32'd3);
    tick();

    // Asynchronous reset in the middle of a full-length frame.
    Start = 1'b1; Data = 16'hF0F0; Len = 5'd16;
    tick();
    Start = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) tick();
    check("rst.pre_pairs", 32'(PairCount), 32'd3);
    check("rst.pre_valid", 32'(Valid), 32'd1);
    Resetn = 1'b0;
    #1;
    check("rst.outputs", 32'({w, Valid, Busy, Done}), 32'd0);
    check("rst.pairs",   32'(PairCount), 32'd0);
    #3;
    Resetn = 1'b1;
    seen = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick();
      if (Valid || Done || Busy) seen = 1'b1;
    end
    check("rst.quiet_after", 32'(seen), 32'd0);

    for (int t = 0; t < 200; t++) begin
      rd = 16'($urandom);
      rl = 5'($urandom_range(0, 31));
      model(rd, rl, mbits, mlen, mpc);
      send_frame($sformatf("rnd%0d", t), rd, rl, mbits, mlen, mpc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
